// File: rtl/reaction_game_ctrl.sv
// Reaction-timer game sequencer: starting lights, random hold, ms reaction count, false-start detection.
// Optional best-time tracking is built when the REACT_BEST_EN macro is defined.
module reaction_game_ctrl #(
  parameter int N_LIGHTS   = 10,
  parameter int DELAY_BITS = 5,
  parameter int COUNT_BITS = 16,
  parameter int MAX_MS     = 9999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_ms,
  input  logic                  tick_hs,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DELAY_BITS-1:0] delay_n,
  output logic                  lfsr_en,
  output logic [N_LIGHTS-1:0]   ledr,
  output logic [COUNT_BITS-1:0] react_ms,
  output logic                  result_valid,
  output logic                  false_start,
  output logic [COUNT_BITS-1:0] best_ms,
  output logic                  new_best
);

  typedef enum logic [2:0] {IDLE, LIGHTS, HOLD, GO, RESULT, FOUL} state_t;

  localparam logic [N_LIGHTS-1:0]   ALL_ON  = '1;
  localparam logic [COUNT_BITS-1:0] MAX_CNT = COUNT_BITS'(MAX_MS);

  state_t                state_q;
  logic                  start_q, stop_q;
  logic [N_LIGHTS-1:0]   ledr_q;
  logic [COUNT_BITS-1:0] react_q;
  logic                  valid_q, foul_q, lfsr_en_q;
  logic [DELAY_BITS-1:0] hold_cnt_q;

  logic                  start_edge, stop_edge;
  logic [COUNT_BITS-1:0] react_inc_d;
  logic [DELAY_BITS-1:0] hold_load_d;

  assign start_edge  = start & ~start_q;
  assign stop_edge   = stop & ~stop_q;
  assign react_inc_d = (react_q < MAX_CNT) ? react_q + COUNT_BITS'(1) : MAX_CNT;
  // A zero delay still holds for one tick so the lights never drop instantly.
  assign hold_load_d = (delay_n == '0) ? DELAY_BITS'(1) : delay_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      start_q    <= 1'b1;
      stop_q     <= 1'b1;
      ledr_q     <= '0;
      react_q    <= '0;
      valid_q    <= 1'b0;
      foul_q     <= 1'b0;
      lfsr_en_q  <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q <= LIGHTS;
            ledr_q  <= '0;
            react_q <= '0;
            valid_q <= 1'b0;
            foul_q  <= 1'b0;
          end
        end
        LIGHTS: begin
          if (stop_edge) begin
            state_q <= FOUL;
            foul_q  <= 1'b1;
            react_q <= '0;
            ledr_q  <= ALL_ON;
          end else if (tick_hs) begin
            ledr_q <= {ledr_q[N_LIGHTS-2:0], 1'b1};
            if (&ledr_q[N_LIGHTS-2:0]) begin
              state_q    <= HOLD;
              hold_cnt_q <= hold_load_d;
              lfsr_en_q  <= 1'b0;
            end
          end
        end
        HOLD: begin
          // Early press beats lights-out, even on the final hold tick.
          if (stop_edge) begin
            state_q   <= FOUL;
            foul_q    <= 1'b1;
            react_q   <= '0;
            ledr_q    <= ALL_ON;
            lfsr_en_q <= 1'b1;
          end else if (tick_hs) begin
            if (hold_cnt_q == DELAY_BITS'(1)) begin
              state_q   <= GO;
              ledr_q    <= '0;
              react_q   <= '0;
              lfsr_en_q <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q - DELAY_BITS'(1);
            end
          end
        end
        GO: begin
          if (stop_edge) begin
            state_q <= RESULT;
            valid_q <= 1'b1;
          end else if (tick_ms) begin
            react_q <= react_inc_d;
            if (react_inc_d == MAX_CNT) begin
              state_q <= RESULT;
              valid_q <= 1'b1;
            end
          end
        end
        RESULT: begin
          if (start_edge) begin
            state_q <= LIGHTS;
            ledr_q  <= '0;
            react_q <= '0;
            valid_q <= 1'b0;
            foul_q  <= 1'b0;
          end
        end
        FOUL: begin
          if (start_edge) begin
            state_q <= LIGHTS;
            ledr_q  <= '0;
            react_q <= '0;
            valid_q <= 1'b0;
            foul_q  <= 1'b0;
          end else if (tick_hs) begin
            ledr_q <= (ledr_q == ALL_ON) ? '0 : ALL_ON;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lfsr_en      = lfsr_en_q;
  assign ledr         = ledr_q;
  assign react_ms     = react_q;
  assign result_valid = valid_q;
  assign false_start  = foul_q;

`ifdef REACT_BEST_EN
  logic [COUNT_BITS-1:0] best_q;
  logic                  new_best_q;

  // Only a stopped measurement can become a best; a timeout enters RESULT at MAX_MS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q     <= MAX_CNT;
      new_best_q <= 1'b0;
    end else begin
      new_best_q <= 1'b0;
      if ((state_q == GO) && stop_edge && (react_q < best_q) && (react_q < MAX_CNT)) begin
        best_q     <= react_q;
        new_best_q <= 1'b1;
      end
    end
  end

  assign best_ms  = best_q;
  assign new_best = new_best_q;
`else
  assign best_ms  = '0;
  assign new_best = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl: full games, false starts, timeout, reset and best-time cases.
module tb_reaction_game_ctrl;

`ifdef REACT_BEST_EN
  localparam bit BEST = 1'b1;
`else
  localparam bit BEST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_ms, tick_hs, start, stop;
  logic [4:0]  delay_n;
  logic        lfsr_en;
  logic [9:0]  ledr;
  logic [15:0] react_ms;
  logic        result_valid, false_start;
  logic [15:0] best_ms;
  logic        new_best;

  int checks   = 0;
  int failures = 0;

  reaction_game_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_ms      (tick_ms),
    .tick_hs      (tick_hs),
    .start        (start),
    .stop         (stop),
    .delay_n      (delay_n),
    .lfsr_en      (lfsr_en),
    .ledr         (ledr),
    .react_ms     (react_ms),
    .result_valid (result_valid),
    .false_start  (false_start),
    .best_ms      (best_ms),
    .new_best     (new_best)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic step(input logic s, input logic p, input logic tm, input logic th);
    start = s; stop = p; tick_ms = tm; tick_hs = th;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_start();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill_lights();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic count_ms(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; tick_ms = 1'b0; tick_hs = 1'b0; delay_n = 5'd3;
    repeat (3) @(negedge clk);
    chk("rst_ledr", 32'(ledr), 32'd0);
    chk("rst_react", 32'(react_ms), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_foul", 32'(false_start), 32'd0);
    chk("rst_lfsr_en", 32'(lfsr_en), 32'd1);
    chk("rst_best", 32'(best_ms), BEST ? 32'd9999 : 32'd0);
    chk("rst_new_best", 32'(new_best), 32'd0);

    // Start held through reset must not launch a game.
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("held_start_no_game", 32'(ledr), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Normal game, delay 3, 250 ms.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("start_tick_in_idle", 32'(ledr), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("lamp_fill", 32'(ledr), (32'd1 << i) - 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("hold_lfsr_frozen", 32'(lfsr_en), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold_after_2", 32'(ledr), 32'h3FF);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lights_out", 32'(ledr), 32'd0);
    chk("go_lfsr_en", 32'(lfsr_en), 32'd1);
    count_ms(250);
    chk("go_count", 32'(react_ms), 32'd250);
    chk("go_not_valid", 32'(result_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("g1_react", 32'(react_ms), 32'd250);
    chk("g1_valid", 32'(result_valid), 32'd1);
    chk("g1_new_best", 32'(new_best), BEST ? 32'd1 : 32'd0);
    chk("g1_best", 32'(best_ms), BEST ? 32'd250 : 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("g1_new_best_pulse", 32'(new_best), 32'd0);
    chk("g1_react_held", 32'(react_ms), 32'd250);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("result_ignores_stop", 32'(false_start), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Jump start in HOLD; restart coincides with tick_hs.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("restart_tick_ledr", 32'(ledr), 32'd0);
    chk("restart_clear_valid", 32'(result_valid), 32'd0);
    chk("restart_clear_react", 32'(react_ms), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    fill_lights();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("jump_foul", 32'(false_start), 32'd1);
    chk("jump_react", 32'(react_ms), 32'd0);
    chk("jump_ledr", 32'(ledr), 32'h3FF);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("foul_toggle_off", 32'(ledr), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("foul_toggle_on", 32'(ledr), 32'h3FF);
    chk("foul_best", 32'(best_ms), BEST ? 32'd250 : 32'd0);
    chk("foul_new_best", 32'(new_best), 32'd0);

    // Stop edge on the tick that would end HOLD: foul wins.
    delay_n = 5'd0;
    press_start();
    chk("restart_clear_foul", 32'(false_start), 32'd0);
    fill_lights();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("foul_beats_go", 32'(false_start), 32'd1);
    chk("foul_beats_go_ledr", 32'(ledr), 32'h3FF);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // delay_n=0 holds one tick; stop coincident with tick_ms at 100.
    press_start();
    fill_lights();
    chk("d0_full", 32'(ledr), 32'h3FF);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("d0_one_tick_hold", 32'(ledr), 32'd0);
    count_ms(100);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("stop_beats_tick", 32'(react_ms), 32'd100);
    chk("stop_beats_tick_valid", 32'(result_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout saturates at 9999 with no best update.
    press_start();
    fill_lights();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    count_ms(9998);
    chk("to_9998", 32'(react_ms), 32'd9998);
    chk("to_9998_valid", 32'(result_valid), 32'd0);
    count_ms(1);
    chk("to_9999", 32'(react_ms), 32'd9999);
    chk("to_valid", 32'(result_valid), 32'd1);
    chk("to_new_best", 32'(new_best), 32'd0);
    count_ms(3);
    chk("to_saturated", 32'(react_ms), 32'd9999);
    chk("to_best", 32'(best_ms), BEST ? 32'd100 : 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in GO at count 40.
    press_start();
    fill_lights();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    count_ms(40);
    chk("pre_rst_count", 32'(react_ms), 32'd40);
    tick_ms = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_react", 32'(react_ms), 32'd0);
    chk("arst_ledr", 32'(ledr), 32'd0);
    chk("arst_lfsr_en", 32'(lfsr_en), 32'd1);
    chk("arst_best", 32'(best_ms), BEST ? 32'd9999 : 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_after_rst", 32'(react_ms), 32'd0);

    // Two games: 180 ms then 300 ms.
    press_start();
    fill_lights();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    count_ms(180);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("g180_react", 32'(react_ms), 32'd180);
    chk("g180_best", 32'(best_ms), BEST ? 32'd180 : 32'd0);
    chk("g180_new_best", 32'(new_best), BEST ? 32'd1 : 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    press_start();
    fill_lights();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    count_ms(300);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("g300_react", 32'(react_ms), 32'd300);
    chk("g300_best", 32'(best_ms), BEST ? 32'd180 : 32'd0);
    chk("g300_new_best", 32'(new_best), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
